// File: rtl/pim_load_pkg.sv
// Shared types and sizing for the PIM output-buffer load sequencer.
package pim_load_pkg;

    localparam int NUM_GROUPS = 32;
    localparam int IDX_W      = 6;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} load_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock capture FIFO with flush; the head word reads as zero when empty.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W:0]    cnt;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PTR_W+1)'(DEPTH));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign count   = cnt;
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/pim_load_sequencer.sv
// Issues load_en/load_cnt to the PIM output buffer, captures the returned words
// into a FIFO and hands them to the peripheral bus, with credit-based flow control.
module pim_load_sequencer
    import pim_load_pkg::load_state_e, pim_load_pkg::IDLE, pim_load_pkg::ISSUE,
           pim_load_pkg::DRAIN, pim_load_pkg::IDX_W;
#(
    parameter int NUM_GROUPS = pim_load_pkg::NUM_GROUPS,
    parameter int DATA_W     = pim_load_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [IDX_W-1:0]  first_idx_i,
    input  logic [IDX_W-1:0]  num_words_i,
    input  logic              abort_i,
    output logic              load_en_o,
    output logic [IDX_W-1:0]  load_cnt_o,
    input  logic [DATA_W-1:0] out_buf_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    load_state_e      state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] rem_q;
    logic [IDX_W-1:0] idx_next;
    logic             capture_q;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W:0]   slots;
    logic             can_issue;
    logic             abort_hit;
    logic             pop;

    // Words already committed to the FIFO: stored, captured this edge, or in flight.
    // A same-cycle pop is deliberately not credited.
    assign slots     = {1'b0, fifo_count} + (CNT_W+1)'(load_en_o) + (CNT_W+1)'(capture_q);
    assign can_issue = (state_q == ISSUE) && (rem_q != '0) && !fifo_full
                       && (slots < (CNT_W+1)'(FIFO_DEPTH));
    assign abort_hit = abort_i && (state_q != IDLE);
    assign idx_next  = (idx_q == IDX_W'(NUM_GROUPS - 1)) ? '0 : idx_q + IDX_W'(1);
    assign rvalid_o  = !fifo_empty;
    assign pop       = rvalid_o && rready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rem_q      <= '0;
            load_en_o  <= 1'b0;
            load_cnt_o <= '0;
            capture_q  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            load_en_o <= 1'b0;
            done_o    <= 1'b0;
            capture_q <= load_en_o;
            if (abort_hit) begin
                state_q   <= IDLE;
                busy_o    <= 1'b0;
                capture_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            if (num_words_i != '0) begin
                                idx_q   <= first_idx_i;
                                rem_q   <= num_words_i;
                                state_q <= ISSUE;
                                busy_o  <= 1'b1;
                            end else begin
                                done_o <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        if (can_issue) begin
                            load_en_o  <= 1'b1;
                            load_cnt_o <= idx_q;
                            idx_q      <= idx_next;
                            rem_q      <= rem_q - IDX_W'(1);
                            if (rem_q == IDX_W'(1)) state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!capture_q && !load_en_o && fifo_empty) begin
                            state_q <= IDLE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (capture_q),
        .pop    (pop),
        .flush  (abort_hit),
        .wdata  (out_buf_i),
        .rdata  (rdata_o),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

endmodule

// File: tb/tb_pim_load_sequencer.sv
// Randomized bench for pim_load_sequencer against a queue-based reference model.
module tb_pim_load_sequencer;

    localparam int NG    = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [5:0]  first_idx_i;
    logic [5:0]  num_words_i;
    logic        abort_i;
    logic        load_en_o;
    logic [5:0]  load_cnt_o;
    logic [31:0] out_buf_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        rready_i;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] bufmem [NG];
    logic [31:0] exp_q [$];
    int exp_idx, exp_num, loads, pops, dones, cyc_n;
    int first_load_cyc, first_valid_cyc, last_load_cyc;
    int rmode, hold_cycles;
    logic prev_stall;
    logic [31:0] prev_rdata;

    // Behavioural output buffer: data for a load appears the cycle after load_en_o.
    logic       ob_v = 1'b0;
    logic [5:0] ob_cnt = '0;
    always @(posedge clk) begin
        ob_v   <= load_en_o;
        ob_cnt <= load_cnt_o;
    end
    assign out_buf_i = ob_v ? bufmem[ob_cnt[4:0]] : 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    pim_load_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .first_idx_i (first_idx_i),
        .num_words_i (num_words_i),
        .abort_i     (abort_i),
        .load_en_o   (load_en_o),
        .load_cnt_o  (load_cnt_o),
        .out_buf_i   (out_buf_i),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_load_en"}, load_en_o, 0);
        check_eq({tag, "_load_cnt"}, load_cnt_o, 0);
        check_eq({tag, "_rvalid"}, rvalid_o, 0);
        check_eq({tag, "_rdata"}, rdata_o, 0);
        check_eq({tag, "_busy"}, busy_o, 0);
        check_eq({tag, "_done"}, done_o, 0);
    endtask

    // One clock: advance, sample outputs, update the model, decide rready.
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        case (rmode)
            0:       rready_i = 1'b1;
            1:       rready_i = 1'($urandom_range(0, 1));
            default: rready_i = (cyc_n > hold_cycles);
        endcase
        if (prev_stall) check_eq("hold", rdata_o, prev_rdata);
        if (load_en_o) begin
            check_eq("load_cnt", load_cnt_o, exp_idx);
            exp_q.push_back(bufmem[exp_idx]);
            exp_idx = (exp_idx + 1) % NG;
            loads++;
            check_eq("load_budget", loads <= exp_num, 1);
            check_eq("credit", (loads - pops) <= DEPTH, 1);
            if (rmode == 0 && loads >= 2) check_eq("back2back", cyc_n - last_load_cyc, 1);
            if (first_load_cyc < 0) first_load_cyc = cyc_n;
            last_load_cyc = cyc_n;
        end
        if (rvalid_o && first_valid_cyc < 0 && first_load_cyc >= 0) begin
            first_valid_cyc = cyc_n;
            check_eq("latency", cyc_n - first_load_cyc, 2);
        end
        if (rvalid_o && rready_i) begin
            check_eq("word_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq("rdata", rdata_o, exp_q.pop_front());
            pops++;
        end
        if (done_o) dones++;
        prev_stall = rvalid_o && !rready_i;
        prev_rdata = rdata_o;
    endtask

    task automatic start_seq(input int first, input int num, input int mode, input int hold, input int pat);
        for (int i = 0; i < NG; i++) bufmem[i] = (pat == 0) ? 32'hA000_0000 + i : $urandom;
        rmode = mode; hold_cycles = hold;
        exp_idx = first; exp_num = num;
        loads = 0; pops = 0; dones = 0; cyc_n = 0;
        first_load_cyc = -1; first_valid_cyc = -1; last_load_cyc = 0;
        exp_q.delete();
        prev_stall = 1'b0;
        start_i = 1'b1; first_idx_i = 6'(first); num_words_i = 6'(num);
        cyc();
        start_i = 1'b0;
        check_eq("busy_rise", busy_o, 1);
    endtask

    task automatic run_seq(input int first, input int num, input int mode, input int hold,
                           input int abort_at, input bit poke, input bit b2b, input int pat);
        start_seq(first, num, mode, hold, pat);
        for (int n = 0; n < 600 && dones == 0; n++) begin
            start_i = poke && (cyc_n == 3);
            if (start_i) begin
                first_idx_i = 6'($urandom_range(0, 31));
                num_words_i = 6'($urandom_range(1, 32));
            end
            if (mode == 2 && cyc_n == hold) begin
                check_eq("bp_loads", loads, DEPTH);
                check_eq("bp_stall", load_en_o, 0);
                check_eq("bp_rvalid", rvalid_o, 1);
            end
            if (abort_at > 0 && loads == abort_at) begin
                start_i = 1'b0;
                abort_i = 1'b1;
                prev_stall = 1'b0;
                cyc();
                abort_i = 1'b0;
                check_eq("abort_load_en", load_en_o, 0);
                check_eq("abort_rvalid", rvalid_o, 0);
                check_eq("abort_busy", busy_o, 0);
                check_eq("abort_done", done_o, 0);
                exp_q.delete();
                exp_num = 0; loads = 0; pops = 0;
                repeat (3) begin
                    cyc();
                    check_eq("post_abort_done", done_o, 0);
                    check_eq("post_abort_busy", busy_o, 0);
                end
                return;
            end
            cyc();
        end
        start_i = 1'b0;
        check_eq("done_seen", dones, 1);
        check_eq("all_loaded", loads, num);
        check_eq("all_consumed", exp_q.size(), 0);
        check_eq("busy_fall", busy_o, 0);
        if (!b2b) begin
            cyc();
            check_eq("done_pulse", done_o, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; rready_i = 1'b1;
        first_idx_i = '0; num_words_i = '0;
        rmode = 0; hold_cycles = 0; prev_stall = 1'b0;
        exp_num = 0; exp_idx = 0; loads = 0; pops = 0; cyc_n = 0;
        first_load_cyc = 0; first_valid_cyc = 0; last_load_cyc = 0;
        for (int i = 0; i < NG; i++) bufmem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_ni = 1'b1;
        cyc();

        // Basic, backpressure, wrap-around
        run_seq(0, 4, 0, 0, 0, 1'b0, 1'b0, 0);
        run_seq(0, 8, 2, 12, 0, 1'b0, 1'b0, 1);
        run_seq(30, 4, 0, 0, 0, 1'b0, 1'b0, 0);

        // Abort after the second load, then a clean sequence
        run_seq(10, 6, 0, 0, 2, 1'b0, 1'b0, 1);
        run_seq(3, 5, 0, 0, 0, 1'b0, 1'b0, 1);

        // Zero-length start
        exp_num = 0; loads = 0;
        start_i = 1'b1; first_idx_i = 6'd9; num_words_i = 6'd0;
        cyc();
        start_i = 1'b0;
        check_eq("nop_done", done_o, 1);
        check_eq("nop_busy", busy_o, 0);
        check_eq("nop_load_en", load_en_o, 0);
        cyc();
        check_eq("nop_done_fall", done_o, 0);
        check_eq("nop_load_en2", load_en_o, 0);

        // Start while busy is ignored
        run_seq(5, 10, 1, 0, 0, 1'b1, 1'b0, 1);

        // Abort in IDLE has no effect
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        check_eq("idle_abort_busy", busy_o, 0);
        check_eq("idle_abort_done", done_o, 0);

        // Start in the same cycle as done
        run_seq(12, 3, 0, 0, 0, 1'b0, 1'b1, 1);
        run_seq(20, 3, 0, 0, 0, 1'b0, 1'b0, 1);

        // Asynchronous reset mid-ISSUE with words queued
        start_seq(5, 8, 2, 1000, 1);
        repeat (4) cyc();
        check_eq("pre_reset_rvalid", rvalid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_quiet("async_reset");
        @(posedge clk);
        #2;
        rst_ni = 1'b1;
        prev_stall = 1'b0;
        exp_q.delete(); exp_num = 0; loads = 0; pops = 0;
        cyc();
        check_eq("post_reset_rvalid", rvalid_o, 0);
        check_eq("post_reset_busy", busy_o, 0);
        check_eq("post_reset_load_en", load_en_o, 0);
        run_seq(31, 2, 0, 0, 0, 1'b0, 1'b0, 1);

        // Randomized sequences
        for (int t = 0; t < 10; t++) begin
            int f, n, ab;
            f  = $urandom_range(0, 31);
            n  = $urandom_range(1, 32);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            run_seq(f, n, 1, 0, ab, 1'b0, 1'($urandom_range(0, 1)), 1);
        end
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
